// File: rtl/adder_share_pkg.sv
// Shared constants and types for the pipelined-adder sharing block.
package adder_share_pkg;

  localparam int DW          = 16;
  localparam int LAT         = 2;
  localparam int NUM_REQ_DEF = 4;

  // Smallest width that can index n requesters (at least 1 bit).
  function automatic int id_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

  typedef struct packed {
    logic                                 v;
    logic [id_width(NUM_REQ_DEF)-1:0]     id;
  } tag_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and response handshake bundle for adder_share_arbiter.
interface adder_share_arbiter_if import adder_share_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; pointer moves only on a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     g
);

  logic [IDW-1:0] ptr_q;
  logic           found;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    g     = ptr_q;
    found = 1'b0;
    grant = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && req[(int'(ptr_q) + off) % NUM_REQ]) begin
        g     = IDW'((int'(ptr_q) + off) % NUM_REQ);
        found = 1'b1;
      end
    end
    if (advance && found) grant[g] = 1'b1;
  end

  // Reset to the last index so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments to avoid simulation races.
    if (rst)                  ptr_q <= IDW'(NUM_REQ - 1);
    else if (advance && found) ptr_q <= g;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one CE-gated pipelined adder among NUM_REQ requesters; a tag pipeline
// matched to the adder latency returns each sum with its requester ID.
module adder_share_arbiter import adder_share_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus,
  output logic                  add_ce,
  output logic [DW-1:0]         add_a,
  output logic [DW-1:0]         add_b,
  input  logic [DW-1:0]         add_s
);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } slot_t;

  slot_t              tag_q [LAT];
  logic               stall;
  logic               issue;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     g;

  // A held response freezes both the adder core and the tags so they stay aligned.
  assign stall  = bus.rsp_valid & ~bus.rsp_ready;
  assign add_ce = ~rst & ~stall;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (add_ce),
    .grant   (grant),
    .g       (g)
  );

  assign issue         = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (issue) begin
      add_a = bus.req_a[int'(g)*DW +: DW];
      add_b = bus.req_b[int'(g)*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the tag stages are reset because their valid bits gate responses;
    // the adder's data path needs no reset since bubbles are never returned.
    if (rst) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else if (add_ce) begin
      tag_q[0] <= '{v: issue, id: g};
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign bus.rsp_valid = tag_q[LAT-1].v;
  assign bus.rsp_id    = tag_q[LAT-1].id;
  assign bus.rsp_data  = add_s;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a CE-gated 2-stage adder model.
module tb_adder_share_arbiter;
  import adder_share_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

  logic          add_ce;
  logic [15:0]   add_a, add_b, add_s;
  logic [15:0]   s0 = '0;
  logic [15:0]   s1 = '0;

  adder_share_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .add_ce (add_ce),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_s  (add_s)
  );

  // Adder core model: latency 2, advances only with CE.
  always @(posedge clk) begin
    if (add_ce) begin
      s0 <= add_a + add_b;
      s1 <= s0;
    end
  end
  assign add_s = s1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] data, input logic [1:0] id);
    check({tag, "_v"},  32'(bus.rsp_valid), 32'd1);
    check({tag, "_d"},  32'(bus.rsp_data),  32'(data));
    check({tag, "_id"}, 32'(bus.rsp_id),    32'(id));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state: outputs forced low even with all requesters valid.
    #1 rst = 1'b1;
    tick();
    bus.req_valid = 4'b1111;
    settle();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_add_ce",    32'(add_ce),        32'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;

    // Single request: 3+4 from requester 0, response two cycles later.
    bus.req_valid = 4'b0001;
    set_op(0, 16'h0003, 16'h0004);
    settle();
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    check("t1_add_a", 32'(add_a), 32'h3);
    check("t1_add_b", 32'(add_b), 32'h4);
    check("t1_ce",    32'(add_ce), 32'd1);
    check("t1_rv0",   32'(bus.rsp_valid), 32'd0);
    tick();
    bus.req_valid = '0;
    settle();
    check("t1_rv1",     32'(bus.rsp_valid), 32'd0);
    check("t1_bubble_a", 32'(add_a), 32'h0);
    tick();
    settle();
    check_rsp("t1_rsp", 16'h0007, 2'd0);
    tick();
    settle();
    check("t1_rv3", 32'(bus.rsp_valid), 32'd0);

    // All four continuously valid: grants rotate, responses back-to-back.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i), 16'h0010);
    for (int k = 0; k <= 10; k++) begin
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      settle();
      check("t2_ready", 32'(bus.req_ready), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
      if (k >= 2 && k < 10) check_rsp("t2_rsp", 16'h0010 + 16'((k - 2) % 4), 2'((k - 2) % 4));
      else                  check("t2_rv0", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // Backpressure: three ops from requester 1, 4-cycle stall on first response.
    do_reset();
    bus.req_valid = 4'b0010;
    set_op(1, 16'h0001, 16'h0001);
    settle();
    check("t3_ready0", 32'(bus.req_ready), 32'h2);
    tick();
    set_op(1, 16'h0002, 16'h0002);
    settle();
    check("t3_ready1", 32'(bus.req_ready), 32'h2);
    check("t3_rv1",    32'(bus.rsp_valid), 32'd0);
    tick();
    set_op(1, 16'h0003, 16'h0003);
    bus.rsp_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      settle();
      check("t3_stall_ce",    32'(add_ce), 32'd0);
      check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
      check_rsp("t3_hold", 16'h0002, 2'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    settle();
    check("t3_rel_ce",    32'(add_ce), 32'd1);
    check("t3_rel_ready", 32'(bus.req_ready), 32'h2);
    check_rsp("t3_r0", 16'h0002, 2'd1);
    tick();
    bus.req_valid = '0;
    settle();
    check_rsp("t3_r1", 16'h0004, 2'd1);
    tick();
    settle();
    check_rsp("t3_r2", 16'h0006, 2'd1);
    tick();
    settle();
    check("t3_rv_end", 32'(bus.rsp_valid), 32'd0);

    // Overflow from requester 3, then pointer wraps to requester 0.
    tick();
    bus.req_valid = 4'b1000;
    set_op(3, 16'hFFFF, 16'h0001);
    settle();
    check("t4_ready0", 32'(bus.req_ready), 32'h8);
    tick();
    set_op(3, 16'h0001, 16'h0001);
    set_op(0, 16'h0005, 16'h0006);
    bus.req_valid = 4'b1001;
    settle();
    check("t4_wrap", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b1000;
    settle();
    check("t4_ready2", 32'(bus.req_ready), 32'h8);
    check_rsp("t4_ovf", 16'h0000, 2'd3);
    tick();
    bus.req_valid = '0;
    settle();
    check_rsp("t4_r1", 16'h000B, 2'd0);
    tick();
    settle();
    check_rsp("t4_r2", 16'h0002, 2'd3);
    tick();
    settle();
    check("t4_rv_end", 32'(bus.rsp_valid), 32'd0);

    // Asynchronous reset with two operations in flight.
    tick();
    set_op(0, 16'h0040, 16'h0004);
    set_op(1, 16'h0011, 16'h0001);
    set_op(2, 16'h0022, 16'h0002);
    bus.req_valid = 4'b0110;
    settle();
    check("t5_ready0", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0100;
    settle();
    check("t5_ready1", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1111;
    settle();
    check_rsp("t5_pre", 16'h0012, 2'd1);
    check("t5_pre_ready", 32'(bus.req_ready), 32'h8);
    rst = 1'b1;
    settle();
    check("t5_rst_rv",    32'(bus.rsp_valid), 32'd0);
    check("t5_rst_ce",    32'(add_ce),        32'd0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("t5_prio0", 32'(bus.req_ready), 32'h1);
    check("t5_rv_a",  32'(bus.rsp_valid), 32'd0);
    tick();
    bus.req_valid = '0;
    settle();
    check("t5_no_stale", 32'(bus.rsp_valid), 32'd0);
    tick();
    settle();
    check_rsp("t5_rsp", 16'h0044, 2'd0);
    tick();
    settle();
    check("t5_rv_end", 32'(bus.rsp_valid), 32'd0);

    // Sparse traffic from requester 2 on alternate cycles.
    tick();
    for (int k = 0; k <= 8; k++) begin
      if (k % 2 == 0 && k < 6) begin
        bus.req_valid = 4'b0100;
        set_op(2, 16'(k * 256), 16'(32 + k));
      end else begin
        bus.req_valid = '0;
      end
      settle();
      check("t6_ready", 32'(bus.req_ready), (k % 2 == 0 && k < 6) ? 32'h4 : 32'h0);
      if (k >= 2 && (k - 2) % 2 == 0 && (k - 2) < 6)
        check_rsp("t6_rsp", 16'((k - 2) * 256 + 32 + (k - 2)), 2'd2);
      else
        check("t6_bubble", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one pipelined 16-bit unsigned adder (the XilinxSPAdderUnsigned core, CE-gated, fixed latency LAT) among NUM_REQ requesters.
- Round-robin arbitration picks one operand pair per cycle.
- A latency-matched tag pipeline carries the requester ID alongside each operation, so each sum returns on a single response port tagged with its origin.
- Response backpressure stalls the whole adder pipeline through CE.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 16, operand/sum width; must match the adder core.
- LAT, 2, adder core latency in CE-enabled cycles.
- IDW, 2, requester ID width; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*DW  packed operand A; requester i uses bits [i*DW +: DW]
- req_b  in  NUM_REQ*DW  packed operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DW  sum (mod 2^DW, carry discarded)
- rsp_id  out  IDW  index of the requester that issued this sum
- add_ce  out  1  CE to adder core
- add_a  out  DW  operand A to adder core
- add_b  out  DW  operand B to adder core
- add_s  in  DW  sum from adder core

Behaviour:
- Reset (async assert, sync release):
  - tag pipeline valid bits = 0, RR pointer = NUM_REQ-1 (requester 0 has first priority).
  - While rst=1: rsp_valid=0, req_ready=0, add_ce=0.
  - In-flight operations are discarded and never returned.
- Stall: stall = rsp_valid & ~rsp_ready.
- CE: add_ce = ~rst & ~stall. The adder pipeline and the tag pipeline advance only when add_ce=1.
- Arbitration (combinational):
  - Search req_valid starting at (ptr+1) mod NUM_REQ and wrapping; the first set bit wins (index g).
  - issue = add_ce & (|req_valid).
  - req_ready[g] = issue; all other bits are 0.
  - req_ready may depend combinationally on req_valid and rsp_ready.
- Operand mux:
  - add_a = req_a[g], add_b = req_b[g] when issue.
  - Otherwise add_a and add_b are held at 0. This gives a deterministic bubble value and is not required for correctness.
- Pointer: on issue, ptr <= g. Otherwise ptr holds, including during stall.
- Tag pipeline: LAT stages of {v, id}.
  - On add_ce: stage0 <= {issue, g}; stage[k] <= stage[k-1].
  - On ~add_ce: all stages hold.
- Response:
  - rsp_valid = stage[LAT-1].v, rsp_id = stage[LAT-1].id, rsp_data = add_s.
  - Alignment holds because the core and the tag pipeline advance on identical CE.
- Throughput and latency:
  - Throughput is 1 op/cycle while unstalled.
  - Accept-to-rsp_valid latency is exactly LAT cycles when no stall occurs.
- Stall detail:
  - While stalled, rsp_valid, rsp_data and rsp_id are held stable, and no request is accepted.
  - The cycle rsp_ready rises, the result is consumed and CE resumes.
- Bubbles: cycles with no issue insert v=0 entries and produce no response.
- The adder wrapper's own valid output is not used: it resets whenever CE drops.
- Requester obligations (AXI-style):
  - A requester holds req_valid and its operands stable until accepted.
  - Same-requester responses return in issue order. All responses return in global issue order.
- Overflow: 0xFFFF+0x0001 -> 0x0000; no carry out.

Decomposition:
- Shared package adder_share_pkg:
  - constants DW, LAT, default NUM_REQ
  - tag_t typedef {logic v; logic [IDW-1:0] id}
  - clog2-based IDW function
- One sub-module, rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, advance strobe, rst.
  - Outputs: one-hot grant and index g.
  - Owns the pointer register.
- Tag pipeline and mux stay in the top level.

Test Plan:
- Single request: req0 valid, a=0x0003, b=0x0004, rsp_ready=1 -> req_ready[0] same cycle; rsp_valid=1 with rsp_data=0x0007, rsp_id=0 exactly 2 cycles later.
- All four requesters continuously valid, with a=i and b=0x10 -> grants rotate 0,1,2,3,0,...; responses arrive back-to-back with rsp_data=0x10+id and ids in that order.
- Backpressure: issue 3 ops from req1 (1+1, 2+2, 3+3), drop rsp_ready for 4 cycles when first rsp_valid appears -> add_ce=0 and req_ready=0 during the stall; rsp held at 0x0002/id1; after release 0x0002, 0x0004, 0x0006 delivered with no loss or duplication.
- Wrap/overflow: req3 a=0xFFFF, b=0x0001 -> rsp_data=0x0000, rsp_id=3; then req0 wins next when req0 and req3 are both valid (pointer wraps).
- Reset mid-operation: assert rst asynchronously (between edges) with 2 ops in flight -> rsp_valid, add_ce and req_ready go 0 immediately; after release no stale responses appear, and requester 0 has priority.
- Sparse traffic: requests on alternate cycles -> one response per request, LAT=2 latency, rsp_valid=0 in bubble cycles.
